fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV64 core, directly upstream of decode.
- Owns the PC and drives the instruction bus, one outstanding request at a time.
- Hands decode one fetch_data_t per instruction, holding it under a decode stall.
- Takes redirects (branch/jump/trap/mret) from later stages and discards wrong-path responses.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  64  request address.
- iresp_addr_ok  in  1  address accepted this cycle.
- iresp_data_ok  in  1  instruction data returned this cycle.
- iresp_data  in  32  returned instruction.
- stall  in  1  decode cannot accept out this cycle.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  64  new fetch target.
- out  out  fetch_data_t  {valid, raw_instr, pc, error} to decode register.

Behaviour:
- Reset (sync, when reset=1 at posedge):
  - pc=PC_RESET, state=REQ, out=0, buffer empty, kill=0.
  - ireq_valid=0 during the reset cycle.
- States:
  - REQ: ireq_valid=1, ireq_addr=pc. On iresp_addr_ok go WAIT and set req_pc=pc, pc<=pc+4 (64-bit wrap).
  - WAIT: ireq_valid=0, wait for iresp_data_ok. addr_ok and data_ok in the same cycle: REQ goes straight to the delivery action, skipping WAIT.
  - STALLED: a response is held in the skid buffer; no request is issued.
- Request rules:
  - ireq_addr is stable from valid assertion until addr_ok.
  - A redirect does not withdraw or alter a pending request.
- Delivery, on data_ok with kill=0:
  - If out.valid=0 or stall=0: out <= {1, iresp_data, req_pc, 0} next cycle and return to REQ.
  - Else: write the skid buffer and go STALLED.
- Consumption:
  - out is consumed in a cycle when out.valid=1 and stall=0.
  - In STALLED, on the cycle stall=0: the buffer moves to out, the buffer empties, and the state goes REQ.
  - With stall=1, out and the buffer hold unchanged.
- Latency: REQ with addr_ok and data_ok in the same cycle gives out.valid the next cycle. Best-case throughput is 1 instruction/cycle.
- Redirect (priority over stall and delivery):
  - Next cycle: out.valid=0, buffer cleared, pc<=redirect_pc.
  - If a transaction is outstanding (WAIT, or REQ without addr_ok this cycle): set kill=1.
    - Case REQ without addr_ok: keep issuing the old address until addr_ok. Then pc stays redirect_pc (no +4) and the state goes WAIT.
    - The matching data_ok is dropped, kill clears, and the state goes REQ.
  - A redirect in the same cycle as data_ok drops that data.
  - A redirect in the same cycle as addr_ok: kill=1, go WAIT.
  - Multiple redirects while kill=1: the last one wins; kill stays 1.
- Misalignment:
  - If pc[1:0]!=0 in REQ: no bus request.
  - Delivery path writes out={1, 32'h0, pc, error=1} (via out or buffer, same stall rules).
  - Then the stage idles in STALLED-like hold (no further requests) until a redirect.
- reset mid-transaction: all state cleared. The stage ignores any later data_ok until it has issued a new request (track an outstanding flag, cleared by reset).
- ireq_valid is never asserted while the buffer is full or kill handling is pending in WAIT.

Decomposition:
- Add fetch_state_t enum {F_REQ, F_WAIT, F_STALLED, F_ERRHOLD} to the shared pipes package.
- Add PC_RESET default as a package constant.
- Reuse fetch_data_t unchanged.
- Natural sub-module: fetch_skid_buf, a one-entry fetch_data_t holding register with load/drain/flush.

Test Plan:
1. Reset, bus answering addr_ok+data_ok same cycle, stall=0:
   - ireq_addr 80000000, 80000004, 80000008 on consecutive cycles.
   - out.pc tracks one cycle later, each with valid=1.
2. Data returns 3 cycles after addr_ok:
   - Exactly one request outstanding; ireq_valid=0 during WAIT.
   - out.valid pulses once per instruction.
3. stall=1 for 4 cycles with out holding pc 80000004 and the next response arriving:
   - out unchanged for all 4 cycles; buffer holds 80000008; no new request.
   - After stall drops: out=80000008, then request 8000000C.
4. redirect_pc=80001000 while in WAIT for 80000010:
   - out.valid=0 next cycle and the 80000010 data is dropped.
   - Next request addr=80001000; out.pc=80001000.
5. redirect_pc=80000002:
   - No bus request; out={valid=1, error=1, pc=80000002, raw_instr=0}.
   - Stage holds until redirect 80000100, then resumes fetching.
6. reset asserted during WAIT, data_ok arriving the cycle after reset deasserts:
   - Response ignored; first request after reset is 80000000; out.valid=0 throughout.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch-stage types and constants
package fetch_stage_pkg;
  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  typedef enum logic [1:0] {F_REQ, F_WAIT, F_STALLED, F_ERRHOLD} fetch_state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        error;
  } fetch_data_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry fetch_data_t holding register with load/drain/flush
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  fetch_data_t din,
  output fetch_data_t dout
);
  always_ff @(posedge clk)
    if (reset || flush) dout <= '0;
    else if (load) dout <= din;
    else if (drain) dout <= '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, single-outstanding instruction fetch with skid buffer and redirect kill
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output fetch_data_t out
);
  fetch_state_t state;
  logic [63:0] pc, req_pc;
  logic kill, issuing, accepted, resp, err, new_ok, can_take, load, drain;
  fetch_data_t buf_q, rec;
  always_comb begin
    issuing  = state == F_REQ && (kill || pc[1:0] == 2'b00);
    accepted = issuing && iresp_addr_ok;
    resp     = iresp_data_ok && (state == F_WAIT || accepted);
    err      = state == F_REQ && !kill && pc[1:0] != 2'b00;
    new_ok   = !redirect_valid && (err || (resp && !kill));
    can_take = !out.valid || !stall;
    load     = new_ok && !can_take;
    drain    = buf_q.valid && !stall;
    rec      = err ? fetch_data_t'{1'b1, 32'h0, pc, 1'b1}
                   : fetch_data_t'{1'b1, iresp_data, state == F_REQ ? pc : req_pc, 1'b0};
  end
  // while a killed request is still waiting for addr_ok, req_pc holds the old address
  assign ireq_valid = issuing && !reset;
  assign ireq_addr  = kill ? req_pc : pc;
  fetch_skid_buf u_skid (
    .clk(clk), .reset(reset), .load(load), .drain(drain),
    .flush(redirect_valid), .din(rec), .dout(buf_q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= F_REQ;
      pc     <= PC_RESET;
      req_pc <= '0;
      kill   <= 1'b0;
      out    <= '0;
    end else if (redirect_valid) begin
      out <= '0;
      pc  <= redirect_pc;
      if (issuing && !iresp_addr_ok) begin
        kill <= 1'b1;
        if (!kill) req_pc <= pc;
      end else if ((accepted || state == F_WAIT) && !iresp_data_ok) begin
        kill  <= 1'b1;
        state <= F_WAIT;
      end else begin
        kill  <= 1'b0;
        state <= F_REQ;
      end
    end else begin
      if (new_ok && can_take) out <= rec;
      else if (drain) out <= buf_q;
      else if (out.valid && !stall) out.valid <= 1'b0;
      if (accepted && !kill) begin
        pc     <= pc + 64'd4;
        req_pc <= pc;
      end
      if (err) state <= F_ERRHOLD;
      else if (resp) begin
        kill  <= 1'b0;
        state <= (kill || can_take) ? F_REQ : F_STALLED;
      end else if (accepted) state <= F_WAIT;
      else if (state == F_STALLED && !stall) state <= F_REQ;
    end
  end
endmodule
